// File: rtl/serial_word_loader_pkg.sv
// Shared word width and FSM state encoding for the serial word loader.
package serial_word_loader_pkg;

  localparam int WORD_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_PAR   = 3'd2,
    S_LOAD  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/serial_word_loader_shift16.sv
// LSB-first shift register with a running even-parity XOR of the bits shifted in.
module ser_shift16
  import serial_word_loader_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             first,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data,
  output logic             parity
);

  // New bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      data   <= '0;
      parity <= 1'b0;
    end else if (shift_en) begin
      data   <= {bit_in, data[WIDTH-1:1]};
      parity <= first ? bit_in : (parity ^ bit_in);
    end
  end

endmodule

// File: rtl/serial_word_loader.sv
// Bit-serial to parallel word loader with valid/ready input, even-parity check and load strobe.
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int WIDTH     = WORD_WIDTH,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             load,
  output logic             busy,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               shift_en;
  logic [WIDTH-1:0]   shift_data;
  logic               shift_par;

  assign accept   = ser_valid && ser_ready;
  assign shift_en = accept && ((state == S_IDLE) || (state == S_SHIFT));

  ser_shift16 #(.WIDTH(WIDTH)) u_shift (
    .clk     (clk),
    .reset   (reset),
    .shift_en(shift_en),
    .first   (state == S_IDLE),
    .bit_in  (ser_data),
    .data    (shift_data),
    .parity  (shift_par)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      word_out   <= '0;
      load       <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
      ser_ready  <= 1'b1;
    end else begin
      load       <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt   <= CNT_W'(1);
            busy  <= 1'b1;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (accept) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              if (PARITY_EN) begin
                state <= S_PAR;
              end else begin
                // The last data bit is still in flight into the shifter, so assemble it here.
                word_out  <= {ser_data, shift_data[WIDTH-1:1]};
                load      <= 1'b1;
                busy      <= 1'b0;
                ser_ready <= 1'b0;
                state     <= S_LOAD;
              end
            end
          end
        end
        S_PAR: begin
          if (accept) begin
            busy      <= 1'b0;
            ser_ready <= 1'b0;
            if ((shift_par ^ ser_data) == 1'b0) begin
              word_out <= shift_data;
              load     <= 1'b1;
              state    <= S_LOAD;
            end else begin
              parity_err <= 1'b1;
              state      <= S_ERR;
            end
          end
        end
        S_LOAD, S_ERR: begin
          cnt       <= '0;
          ser_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          cnt       <= '0;
          busy      <= 1'b0;
          ser_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader: reset, good/bad parity, stalls, mid-frame reset, back-to-back.
module tb_serial_word_loader;

  logic        clk;
  logic        reset;
  logic        ser_valid;
  logic        ser_data;
  logic        ser_ready;
  logic [15:0] word_out;
  logic        load;
  logic        busy;
  logic        parity_err;

  int checks = 0;
  int errors = 0;
  int loads = 0;
  int errs = 0;
  int both = 0;
  int bad_ready = 0;
  int cyc = 0;
  int last_load_cyc = 0;
  int accepted = 0;
  logic lat_load;

  serial_word_loader dut (
    .clk       (clk),
    .reset     (reset),
    .ser_valid (ser_valid),
    .ser_data  (ser_data),
    .ser_ready (ser_ready),
    .word_out  (word_out),
    .load      (load),
    .busy      (busy),
    .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive at the falling edge, observe outputs at the next falling edge.
  task automatic step(input logic v, input logic d, output logic acc);
    ser_valid = v;
    ser_data  = d;
    if (ser_ready === (load || parity_err)) bad_ready++;
    acc = v && ser_ready;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (load) begin
      loads++;
      last_load_cyc = cyc;
    end
    if (parity_err) errs++;
    if (load && parity_err) both++;
  endtask

  task automatic send_bit(input logic b, input bit rnd);
    logic acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      step(rnd ? 1'($urandom_range(0, 1)) : 1'b1, b, acc);
      tries++;
    end
    if (acc) accepted++;
    else begin
      checks++;
      errors++;
      $display("FAIL send_bit_timeout: bit not accepted after %0d cycles, required accept", tries);
    end
  endtask

  task automatic send_frame(input logic [15:0] w, input logic p, input bit rnd);
    for (int i = 0; i < 16; i++) send_bit(w[i], rnd);
    send_bit(p, rnd);
    lat_load = load;
  endtask

  task automatic idle_cycle();
    logic acc;
    step(1'b0, 1'b0, acc);
  endtask

  task automatic do_reset();
    logic acc;
    reset = 1'b1;
    step(1'b0, 1'b0, acc);
    step(1'b0, 1'b0, acc);
    reset = 1'b0;
    loads = 0;
    errs  = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (word_out !== 16'h0000) begin errors++; $display("FAIL reset_word: got %h want 0000", word_out); end
    checks++;
    if ({ser_ready, load, parity_err, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: got ready/load/perr/busy=%b want 1000", {ser_ready, load, parity_err, busy});
    end
  endtask

  task automatic test_good_frame();
    loads = 0; errs = 0;
    send_frame(16'hA5C3, 1'b0, 1'b0);
    checks++;
    if (lat_load !== 1'b1) begin errors++; $display("FAIL good_latency: load=%b after parity, want 1", lat_load); end
    idle_cycle();
    idle_cycle();
    checks++;
    if (word_out !== 16'hA5C3) begin errors++; $display("FAIL good_word: got %h want a5c3", word_out); end
    checks++;
    if (loads !== 1 || errs !== 0) begin
      errors++;
      $display("FAIL good_strobes: loads=%0d perrs=%0d want 1 0", loads, errs);
    end
  endtask

  task automatic test_parity_err();
    loads = 0; errs = 0;
    send_frame(16'h0001, 1'b1, 1'b0);
    idle_cycle();
    checks++;
    if (word_out !== 16'h0001 || loads !== 1) begin
      errors++;
      $display("FAIL par_ok: word=%h loads=%0d want 0001 1", word_out, loads);
    end
    loads = 0; errs = 0;
    send_frame(16'h0001, 1'b0, 1'b0);
    checks++;
    if (parity_err !== 1'b1) begin errors++; $display("FAIL par_err_latency: parity_err=%b want 1", parity_err); end
    idle_cycle();
    idle_cycle();
    checks++;
    if (errs !== 1 || loads !== 0) begin
      errors++;
      $display("FAIL par_err_strobes: perrs=%0d loads=%0d want 1 0", errs, loads);
    end
    checks++;
    if (word_out !== 16'h0001) begin errors++; $display("FAIL par_err_word: got %h want 0001", word_out); end
  endtask

  task automatic test_random_valid();
    loads = 0; errs = 0; accepted = 0;
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b1);
    checks++;
    if (busy !== 1'b1 || loads !== 0) begin
      errors++;
      $display("FAIL rnd_midframe: busy=%b loads=%0d want 1 0", busy, loads);
    end
    for (int i = 8; i < 16; i++) send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    idle_cycle();
    idle_cycle();
    checks++;
    if (word_out !== 16'hFFFF || loads !== 1 || errs !== 0) begin
      errors++;
      $display("FAIL rnd_frame: word=%h loads=%0d perrs=%0d want ffff 1 0", word_out, loads, errs);
    end
    checks++;
    if (accepted !== 17 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rnd_bitcount: accepted=%0d busy=%b want 17 0", accepted, busy);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] w;
    w = 16'h1234;
    for (int i = 0; i < 9; i++) send_bit(w[i], 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    loads = 0;
    reset = 1'b1;
    idle_cycle();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || word_out !== 16'h0000 || ser_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: busy=%b word=%h ready=%b want 0 0000 1", busy, word_out, ser_ready);
    end
    idle_cycle();
    checks++;
    if (loads !== 0) begin errors++; $display("FAIL mid_noload: loads=%0d want 0", loads); end
    send_frame(16'h1234, 1'b1, 1'b0);
    idle_cycle();
    checks++;
    if (word_out !== 16'h1234 || loads !== 1) begin
      errors++;
      $display("FAIL mid_reload: word=%h loads=%0d want 1234 1", word_out, loads);
    end
  endtask

  task automatic test_back_to_back();
    int first_cyc;
    loads = 0; errs = 0; bad_ready = 0;
    send_frame(16'h5A5A, 1'b0, 1'b0);
    first_cyc = last_load_cyc;
    checks++;
    if (word_out !== 16'h5A5A) begin errors++; $display("FAIL b2b_word1: got %h want 5a5a", word_out); end
    send_frame(16'h0F0E, 1'b1, 1'b0);
    checks++;
    if (last_load_cyc - first_cyc !== 18) begin
      errors++;
      $display("FAIL b2b_gap: load spacing %0d cycles want 18", last_load_cyc - first_cyc);
    end
    idle_cycle();
    checks++;
    if (word_out !== 16'h0F0E || loads !== 2) begin
      errors++;
      $display("FAIL b2b_word2: word=%h loads=%0d want 0f0e 2", word_out, loads);
    end
    checks++;
    if (bad_ready !== 0) begin errors++; $display("FAIL b2b_ready: %0d cycles with wrong ser_ready, want 0", bad_ready); end
    checks++;
    if (both !== 0) begin errors++; $display("FAIL strobe_overlap: %0d cycles load&parity_err, want 0", both); end
  endtask

  initial begin
    reset     = 1'b1;
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_parity_err();
    test_random_valid();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
